wave_gen_mc: RTL and testbench
==============================

WAVE_GEN_MC -- requirements
Module: wave_gen_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent channels (1..4).
REQ-002 SHALL have parameter OUT_W, default 12, output sample width per channel (8..16).
REQ-003 SHALL have parameter ACC_W, default 24, phase accumulator width (OUT_W+4..32).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wstrb  input  4  byte strobes; any bit set = write.
REQ-007 SHALL have port addr  input  32  bus address; block selected when addr[31:24]==8'h04.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  combinational read data for addressed register.
REQ-010 SHALL have port wave  output  N_CH*OUT_W  concatenated samples; channel i at [i*OUT_W +: OUT_W].

Function
REQ-011 SHALL decode addr[6:4] as channel index (7 = global) and addr[3:2] as register index.
REQ-012 Per-channel registers SHALL be: 0 CTRL {en[3], mode[2:0]}, 1 FREQ (ACC_W-bit phase increment), 2 AMP (OUT_W bits), 3 DUTY (8 bits).
REQ-013 Global registers SHALL be: 0 SYNC (write-only; bit i set clears channel i accumulator), 1 STATUS (read-only {N_CH[11:8], sine_present[0]}); other global indices read 0.
REQ-014 Writes to channel index >= N_CH and <7 SHALL be ignored; reads SHALL return 0.
REQ-015 Modes SHALL be 0 OFF, 1 SQUARE, 2 SAW, 3 TRI, 4 SINE, 5 NOISE; 6,7 behave as OFF.
REQ-016 Each enabled channel SHALL add FREQ to its accumulator every cycle, wrapping modulo 2^ACC_W; disabled channel SHALL hold accumulator.
REQ-017 Phase p SHALL be acc[ACC_W-1 -: OUT_W]; SQUARE raw = (acc[ACC_W-1 -: 8] < DUTY) ? all-ones : 0; SAW raw = p; TRI raw = {p[OUT_W-2:0],0} when p MSB=0, else its bitwise inverse.
REQ-018 NOISE SHALL use a per-channel 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing once per accumulator wrap; raw = lfsr[15 -: OUT_W] (zero-extended if OUT_W>16 not allowed).
REQ-019 Output SHALL be (raw*AMP)>>OUT_W, truncated; OFF or en=0 SHALL output 0.
REQ-020 Pipeline SHALL be two cycles: accumulator register -> raw register -> wave register.
REQ-021 A CTRL write that changes mode SHALL clear that channel's accumulator on the same edge; FREQ/AMP/DUTY writes SHALL take effect without clearing phase.
REQ-022 SYNC write coincident with accumulator update SHALL win (accumulator = 0 after edge).
REQ-023 SYNC writes SHALL clear all selected channels on the same edge, giving phase-aligned outputs.

Reset
REQ-024 rst SHALL asynchronously clear all registers, accumulators and wave to 0, and load every LFSR with 16'hACE1.
REQ-025 Reset mid-operation SHALL zero wave immediately; first non-zero sample SHALL appear no earlier than 2 cycles after release and configuration.

Configuration
REQ-026 Macro WAVE_GEN_MC_SINE_EN SHALL, when defined, include a 64-entry quarter-wave sine table (mirrored by p[OUT_W-2], negated by p MSB, offset mid-scale) driving mode 4 and STATUS[0]=1.
REQ-027 Without WAVE_GEN_MC_SINE_EN, mode 4 SHALL behave as OFF and STATUS[0]=0.

Verification
REQ-028 Defaults, ch0 CTRL=0xA, FREQ=0x100000, AMP=0xFFF -> wave[11:0] ramps 0,255,511,...,3839 then 0, period 16 cycles.
REQ-029 ch0 SQUARE, DUTY=0x40, FREQ=0x10000, AMP=0xFFF -> high 4094 for 64 cycles, 0 for 192 cycles.
REQ-030 ch0 and ch1 SAW with different phase, write SYNC=0x3 -> both channels output identical samples from 2 cycles after write.
REQ-031 Read global STATUS with N_CH=2 -> 0x201 with macro, 0x200 without; read channel 5 -> 0.
REQ-032 Assert rst mid-TRI -> wave 0 same cycle; LFSR reads seed 0xACE1-derived sequence after release in NOISE mode.

Source files
------------

// File: rtl/wave_gen_mc.sv
// Multi-channel waveform generator with a small memory-mapped register file.
// Each channel runs a phase accumulator and produces SQUARE / SAW / TRI / NOISE
// samples (plus SINE when WAVE_GEN_MC_SINE_EN is defined), scaled by AMP.
// Pipeline: accumulator -> raw sample register -> wave register.
// Optional feature macro: WAVE_GEN_MC_SINE_EN (quarter-wave sine table, mode 4).
module wave_gen_mc #(
  parameter int N_CH  = 2,
  parameter int OUT_W = 12,
  parameter int ACC_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [N_CH*OUT_W-1:0] wave
);
  localparam logic [2:0] CH_GLOBAL = 3'd7;
`ifdef WAVE_GEN_MC_SINE_EN
  localparam logic SINE_PRESENT = 1'b1;
  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);

  // Quarter-wave sine magnitude, full scale 32767, 64 steps over 0..90 degrees
  function automatic logic [14:0] sine_q(input logic [5:0] idx);
    logic [14:0] v;
    case (idx)
      6'd0:  v = 15'd0;     6'd1:  v = 15'd804;   6'd2:  v = 15'd1608;  6'd3:  v = 15'd2410;
      6'd4:  v = 15'd3212;  6'd5:  v = 15'd4011;  6'd6:  v = 15'd4808;  6'd7:  v = 15'd5602;
      6'd8:  v = 15'd6393;  6'd9:  v = 15'd7179;  6'd10: v = 15'd7962;  6'd11: v = 15'd8739;
      6'd12: v = 15'd9512;  6'd13: v = 15'd10278; 6'd14: v = 15'd11039; 6'd15: v = 15'd11793;
      6'd16: v = 15'd12539; 6'd17: v = 15'd13279; 6'd18: v = 15'd14010; 6'd19: v = 15'd14732;
      6'd20: v = 15'd15446; 6'd21: v = 15'd16151; 6'd22: v = 15'd16846; 6'd23: v = 15'd17530;
      6'd24: v = 15'd18204; 6'd25: v = 15'd18868; 6'd26: v = 15'd19519; 6'd27: v = 15'd20159;
      6'd28: v = 15'd20787; 6'd29: v = 15'd21403; 6'd30: v = 15'd22005; 6'd31: v = 15'd22594;
      6'd32: v = 15'd23170; 6'd33: v = 15'd23731; 6'd34: v = 15'd24279; 6'd35: v = 15'd24811;
      6'd36: v = 15'd25329; 6'd37: v = 15'd25832; 6'd38: v = 15'd26319; 6'd39: v = 15'd26790;
      6'd40: v = 15'd27245; 6'd41: v = 15'd27683; 6'd42: v = 15'd28105; 6'd43: v = 15'd28510;
      6'd44: v = 15'd28898; 6'd45: v = 15'd29268; 6'd46: v = 15'd29621; 6'd47: v = 15'd29956;
      6'd48: v = 15'd30273; 6'd49: v = 15'd30571; 6'd50: v = 15'd30852; 6'd51: v = 15'd31113;
      6'd52: v = 15'd31356; 6'd53: v = 15'd31580; 6'd54: v = 15'd31785; 6'd55: v = 15'd31971;
      6'd56: v = 15'd32137; 6'd57: v = 15'd32285; 6'd58: v = 15'd32412; 6'd59: v = 15'd32521;
      6'd60: v = 15'd32609; 6'd61: v = 15'd32678; 6'd62: v = 15'd32728; default: v = 15'd32757;
    endcase
    return v;
  endfunction
`else
  localparam logic SINE_PRESENT = 1'b0;
`endif

  logic       w_sel, w_wr, w_sync, w_unused;
  logic [2:0] w_ch;
  logic [1:0] w_reg;

  assign w_sel    = (addr[31:24] == 8'h04);
  assign w_wr     = w_sel && (|wstrb);
  assign w_ch     = addr[6:4];
  assign w_reg    = addr[3:2];
  assign w_sync   = w_wr && (w_ch == CH_GLOBAL) && (w_reg == 2'd0);
  assign w_unused = ^{addr, wdata};

  // Per-channel register views for the read mux
  logic [N_CH-1:0][3:0]       w_ctrl_a;
  logic [N_CH-1:0][ACC_W-1:0] w_freq_a;
  logic [N_CH-1:0][OUT_W-1:0] w_amp_a;
  logic [N_CH-1:0][7:0]       w_duty_a;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [3:0]         r_ctrl;
    logic [ACC_W-1:0]   r_freq, r_acc;
    logic [OUT_W-1:0]   r_amp, r_raw, r_wave;
    logic [7:0]         r_duty;
    logic [15:0]        r_lfsr;
    logic               w_wr_ch, w_mode_chg, w_clr, w_en, w_lfsr_fb, w_prod_unused;
    logic [ACC_W:0]     w_sum;
    logic [OUT_W-1:0]   w_p, w_tri, w_raw;
    logic [2*OUT_W-1:0] w_prod;

    assign w_wr_ch    = w_wr && (w_ch == 3'(g));
    // Only a change of waveform restarts the phase; toggling enable does not
    assign w_mode_chg = w_wr_ch && (w_reg == 2'd0) && (wdata[2:0] != r_ctrl[2:0]);
    assign w_clr      = w_mode_chg || (w_sync && wdata[g]);
    assign w_en       = r_ctrl[3];
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_freq};
    assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_p        = r_acc[ACC_W-1 -: OUT_W];
    assign w_tri      = w_p[OUT_W-1] ? ~{w_p[OUT_W-2:0], 1'b0} : {w_p[OUT_W-2:0], 1'b0};
    assign w_prod     = r_raw * r_amp;
    assign w_prod_unused = ^w_prod[OUT_W-1:0];

`ifdef WAVE_GEN_MC_SINE_EN
    logic [5:0]       w_sidx;
    logic [14:0]      w_q;
    logic [OUT_W-1:0] w_smag, w_sine;
    // Second and fourth quarters read the table backwards; lower half is below mid-scale
    assign w_sidx = w_p[OUT_W-2] ? ~w_p[OUT_W-3 -: 6] : w_p[OUT_W-3 -: 6];
    assign w_q    = sine_q(w_sidx);
    assign w_smag = {1'b0, w_q[14 -: (OUT_W-1)]};
    assign w_sine = w_p[OUT_W-1] ? (MID - w_smag) : (MID + w_smag);
`endif

    // Raw sample selection from the current phase and mode
    always_comb begin
      w_raw = '0;
      if (w_en) begin
        case (r_ctrl[2:0])
          3'd1:    w_raw = (r_acc[ACC_W-1 -: 8] < r_duty) ? {OUT_W{1'b1}} : '0;
          3'd2:    w_raw = w_p;
          3'd3:    w_raw = w_tri;
`ifdef WAVE_GEN_MC_SINE_EN
          3'd4:    w_raw = w_sine;
`endif
          3'd5:    w_raw = r_lfsr[15 -: OUT_W];
          default: w_raw = '0;
        endcase
      end
    end

    // Channel configuration registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ctrl <= '0;
        r_freq <= '0;
        r_amp  <= '0;
        r_duty <= '0;
      end else if (w_wr_ch) begin
        case (w_reg)
          2'd0:    r_ctrl <= wdata[3:0];
          2'd1:    r_freq <= wdata[ACC_W-1:0];
          2'd2:    r_amp  <= wdata[OUT_W-1:0];
          default: r_duty <= wdata[7:0];
        endcase
      end
    end

    // Phase accumulator and noise LFSR; a clear beats the increment and suppresses the LFSR step
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc  <= '0;
        r_lfsr <= 16'hACE1;
      end else begin
        if (w_clr)     r_acc <= '0;
        else if (w_en) r_acc <= w_sum[ACC_W-1:0];
        if (!w_clr && w_en && w_sum[ACC_W]) r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      end
    end

    // Output pipeline: raw sample, then amplitude-scaled sample
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_raw  <= '0;
        r_wave <= '0;
      end else begin
        r_raw  <= w_raw;
        r_wave <= w_prod[2*OUT_W-1 -: OUT_W];
      end
    end

    assign wave[g*OUT_W +: OUT_W] = r_wave;
    assign w_ctrl_a[g] = r_ctrl;
    assign w_freq_a[g] = r_freq;
    assign w_amp_a[g]  = r_amp;
    assign w_duty_a[g] = r_duty;
  end

  // Combinational register read-back; unmapped locations read 0
  always_comb begin
    rdata = '0;
    if (w_sel) begin
      if (w_ch == CH_GLOBAL) begin
        if (w_reg == 2'd1) rdata = {20'd0, 4'(N_CH), 7'd0, SINE_PRESENT};
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (w_ch == 3'(i)) begin
            case (w_reg)
              2'd0:    rdata = {28'd0, w_ctrl_a[i]};
              2'd1:    rdata = 32'(w_freq_a[i]);
              2'd2:    rdata = 32'(w_amp_a[i]);
              default: rdata = {24'd0, w_duty_a[i]};
            endcase
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_wave_gen_mc.sv
// Randomized scoreboard bench for wave_gen_mc: a driver applies bus traffic and
// pushes the reference model's expected wave/rdata; a negedge monitor compares.
module tb_wave_gen_mc;
  localparam int     N_CH    = 2;
  localparam int     OUT_W   = 12;
  localparam int     ACC_W   = 24;
  localparam longint ACC_MOD = 64'd1 << ACC_W;
  localparam int     OUT_MAX = (1 << OUT_W) - 1;
`ifdef WAVE_GEN_MC_SINE_EN
  localparam int     SINE    = 1;
`else
  localparam int     SINE    = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [3:0]            wstrb = '0;
  logic [31:0]           addr = '0;
  logic [31:0]           wdata = '0;
  logic [31:0]           rdata;
  logic [N_CH*OUT_W-1:0] wave;

  wave_gen_mc #(.N_CH(N_CH), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .rdata(rdata), .wave(wave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH*OUT_W-1:0] wave;
    bit                    chk_rd;
    logic [31:0]           rd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int     m_ctrl[N_CH], m_amp[N_CH], m_duty[N_CH], m_lfsr[N_CH], m_raw[N_CH], m_wave[N_CH];
  longint m_freq[N_CH], m_acc[N_CH];

  function automatic void reset_model();
    for (int i = 0; i < N_CH; i++) begin
      m_ctrl[i] = 0; m_amp[i] = 0; m_duty[i] = 0; m_raw[i] = 0; m_wave[i] = 0;
      m_freq[i] = 0; m_acc[i] = 0; m_lfsr[i] = 'hACE1;
    end
  endfunction

  function automatic int raw_of(int i);
    int     mode;
    longint p;
    mode = m_ctrl[i] & 7;
    p    = m_acc[i] >> (ACC_W - OUT_W);
    if ((m_ctrl[i] & 8) == 0) return 0;
    case (mode)
      1: return ((m_acc[i] >> (ACC_W - 8)) < m_duty[i]) ? OUT_MAX : 0;
      2: return int'(p);
      3: begin
        if (p < (OUT_MAX + 1) / 2) return int'(2 * p);
        return OUT_MAX - int'((2 * p) % (OUT_MAX + 1));
      end
      5: return m_lfsr[i] >> (16 - OUT_W);
      default: return 0;
    endcase
  endfunction

  function automatic void model_edge(logic [3:0] s, logic [31:0] a, logic [31:0] d);
    int     nraw[N_CH], nwave[N_CH];
    bit     wr, clr;
    int     ch, r, b;
    longint sum;
    wr = (a[31:24] == 8'h04) && (s != 0);
    ch = int'(a[6:4]);
    r  = int'(a[3:2]);
    for (int i = 0; i < N_CH; i++) begin
      nwave[i] = (m_raw[i] * m_amp[i]) >> OUT_W;
      nraw[i]  = raw_of(i);
    end
    for (int i = 0; i < N_CH; i++) begin
      clr = (wr && ch == 7 && r == 0 && d[i]) ||
            (wr && ch == i && r == 0 && (int'(d[2:0]) != (m_ctrl[i] & 7)));
      if (clr) m_acc[i] = 0;
      else if ((m_ctrl[i] & 8) != 0) begin
        sum = m_acc[i] + m_freq[i];
        if (sum >= ACC_MOD) begin
          b = (m_lfsr[i] ^ (m_lfsr[i] >> 2) ^ (m_lfsr[i] >> 3) ^ (m_lfsr[i] >> 5)) & 1;
          m_lfsr[i] = (m_lfsr[i] >> 1) | (b << 15);
        end
        m_acc[i] = sum % ACC_MOD;
      end
      if (wr && ch == i) begin
        case (r)
          0: m_ctrl[i] = int'(d & 32'hF);
          1: m_freq[i] = longint'(d) % ACC_MOD;
          2: m_amp[i]  = int'(d) & OUT_MAX;
          default: m_duty[i] = int'(d & 32'hFF);
        endcase
      end
      m_raw[i]  = nraw[i];
      m_wave[i] = nwave[i];
    end
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    int ch, r;
    ch = int'(a[6:4]);
    r  = int'(a[3:2]);
    if (a[31:24] != 8'h04) return 32'd0;
    if (ch == 7) return (r == 1) ? 32'((N_CH << 8) | SINE) : 32'd0;
    if (ch >= N_CH) return 32'd0;
    case (r)
      0: return 32'(m_ctrl[ch]);
      1: return 32'(m_freq[ch]);
      2: return 32'(m_amp[ch]);
      default: return 32'(m_duty[ch]);
    endcase
  endfunction

  function automatic logic [N_CH*OUT_W-1:0] pack_wave();
    logic [N_CH*OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < N_CH; i++) w[i*OUT_W +: OUT_W] = OUT_W'(m_wave[i]);
    return w;
  endfunction

  // One bus cycle: drive inputs just after a rising edge, queue expectations, advance model
  task automatic step(input logic r, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input bit chk);
    exp_t e;
    rst = r; wstrb = s; addr = a; wdata = d;
    if (r) reset_model();
    e.wave = pack_wave();
    e.chk_rd = chk;
    e.rd = exp_rd(a);
    q.push_back(e);
    @(posedge clk);
    if (r) reset_model();
    else   model_edge(s, a, d);
    #1;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    step(1'b0, 4'hF, 32'h0400_0000 | 32'(ch << 4) | 32'(r << 2), d, 1'b0);
  endtask

  task automatic rd(input int ch, input int r);
    step(1'b0, 4'h0, 32'h0400_0000 | 32'(ch << 4) | 32'(r << 2), 32'd0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'h0, 32'h0400_0000, 32'd0, 1'b0);
  endtask

  // Monitor: compare every presented sample (and read data when requested)
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (wave !== mon_e.wave) begin
        errors++;
        $display("FAIL wave @%0t: got %h want %h", $time, wave, mon_e.wave);
      end
      if (mon_e.chk_rd) begin
        checks++;
        if (rdata !== mon_e.rd) begin
          errors++;
          $display("FAIL rdata addr=%h @%0t: got %h want %h", addr, $time, rdata, mon_e.rd);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int          k, ch, r;
    reset_model();
    @(posedge clk); #1;
    // Reset state
    step(1'b1, 4'h0, 32'h0400_0000, 32'd0, 1'b1);
    step(1'b1, 4'h0, 32'h0400_0074, 32'd0, 1'b1);
    step(1'b0, 4'h0, 32'h0400_0000, 32'd0, 1'b1);

    // Sawtooth ramp
    wr(0, 1, 32'h0010_0000); wr(0, 2, 32'hFFF); wr(0, 0, 32'hA);
    idle(40);

    // Register read-back, status, unmapped channel and unselected block
    for (int i = 0; i < 4; i++) rd(0, i);
    rd(1, 0); rd(5, 0); rd(5, 2); rd(7, 0); rd(7, 1); rd(7, 2);
    step(1'b0, 4'h0, 32'h0500_0074, 32'd0, 1'b1);
    step(1'b0, 4'hF, 32'h0400_0050, 32'h5, 1'b0);
    rd(5, 0);

    // Square with 25% duty
    wr(0, 3, 32'h40); wr(0, 1, 32'h0001_0000); wr(0, 0, 32'h9);
    idle(300);

    // Two saws, then synchronize
    wr(1, 1, 32'h0010_0000); wr(1, 2, 32'hFFF); wr(1, 0, 32'hA);
    wr(0, 1, 32'h0010_0000); wr(0, 0, 32'hA);
    idle(5);
    wr(7, 0, 32'h3);
    idle(20);

    // Reset in the middle of a triangle, then noise from the seed
    wr(0, 1, 32'h0003_0000); wr(0, 0, 32'hB);
    idle(30);
    step(1'b1, 4'h0, 32'h0400_0000, 32'd0, 1'b0);
    step(1'b1, 4'h0, 32'h0400_0000, 32'd0, 1'b0);
    idle(2);
    wr(0, 1, 32'h0080_0000); wr(0, 2, 32'hFFF); wr(0, 0, 32'hD);
    idle(40);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      k  = $urandom_range(99);
      ch = $urandom_range(7);
      r  = $urandom_range(3);
      a  = 32'h0400_0000 | 32'(ch << 4) | 32'(r << 2) | 32'($urandom_range(3));
      if ($urandom_range(9) == 0) a[31:24] = 8'($urandom);
      d  = $urandom;
      if (r == 0 && ch != 7) begin
        if ($urandom_range(3) != 0) d[3] = 1'b1;
        if (SINE == 1 && d[2:0] == 3'd4) d[2:0] = 3'd2;
      end
      if (k < 1)       step(1'b1, 4'h0, a, d, 1'b1);
      else if (k < 45) step(1'b0, 4'h0, a, d, 1'b1);
      else if (k < 50) step(1'b0, 4'h1, 32'h0400_0070, d, 1'b0);
      else             step(1'b0, 4'($urandom_range(15, 1)), a, d, 1'b0);
    end
    idle(2);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
